// File: rtl/memcopy_sequencer.sv
// rtl/memcopy_sequencer.sv - multi-cycle memcopy engine over the data-memory port (optional MEMCOPY_ABORT_EN)
module memcopy_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef MEMCOPY_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len_words,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WRITE, S_FINISH} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr, src_nxt, dst_nxt, addr_nxt;
    logic [LEN_WIDTH-1:0]  remain, remain_nxt;
    logic [DATA_WIDTH-1:0] data_buf, buf_nxt;
    logic                  err_nxt;
    logic                  abort_req, abort_q_nxt, aborted_nxt;

`ifdef MEMCOPY_ABORT_EN
    logic abort_q;
    // An abort seen while an access is stalled is remembered until that access completes.
    assign abort_req = abort | abort_q;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        src_nxt     = src_ptr;
        dst_nxt     = dst_ptr;
        remain_nxt  = remain;
        buf_nxt     = data_buf;
        err_nxt     = err;
        aborted_nxt = 1'b0;
        abort_q_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    src_nxt    = src_addr;
                    dst_nxt    = dst_addr;
                    remain_nxt = len_words;
                    state_nxt  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort_req) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = S_FINISH;
                end else if (|((src_ptr | dst_ptr) & ALIGN_MASK)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_FINISH;
                end else if (remain == '0) begin
                    state_nxt = S_FINISH;
                end else begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                abort_q_nxt = abort_req;
                if (mem_ready) begin
                    buf_nxt     = mem_rdata;
                    abort_q_nxt = 1'b0;
                    if (abort_req) begin
                        aborted_nxt = 1'b1;
                        state_nxt   = S_FINISH;
                    end else begin
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                abort_q_nxt = abort_req;
                if (mem_ready) begin
                    src_nxt     = src_ptr + STRIDE;
                    dst_nxt     = dst_ptr + STRIDE;
                    remain_nxt  = remain - LEN_WIDTH'(1);
                    abort_q_nxt = 1'b0;
                    if (remain_nxt == '0) begin
                        state_nxt = S_FINISH;
                    end else if (abort_req) begin
                        aborted_nxt = 1'b1;
                        state_nxt   = S_FINISH;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_FINISH: begin
                err_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are registered from the next state so the memory port sees no combinational path.
        case (state_nxt)
            S_READ:  addr_nxt = src_nxt;
            S_WRITE: addr_nxt = dst_nxt;
            default: addr_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remain    <= '0;
            data_buf  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_nxt;
            src_ptr   <= src_nxt;
            dst_ptr   <= dst_nxt;
            remain    <= remain_nxt;
            data_buf  <= buf_nxt;
            busy      <= (state_nxt == S_CHECK) || (state_nxt == S_READ) || (state_nxt == S_WRITE);
            done      <= (state_nxt == S_FINISH);
            err       <= err_nxt;
            mem_rd_en <= (state_nxt == S_READ);
            mem_wr_en <= (state_nxt == S_WRITE);
            mem_addr  <= addr_nxt;
        end
    end

    assign mem_wdata = data_buf;

`ifdef MEMCOPY_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
            aborted <= 1'b0;
        end else begin
            abort_q <= abort_q_nxt;
            aborted <= aborted_nxt;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = abort_q_nxt | aborted_nxt;
`endif

endmodule

// File: tb/tb_memcopy_sequencer.sv
// tb/tb_memcopy_sequencer.sv - table-driven bench for memcopy_sequencer with a wait-state memory model
module tb_memcopy_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic        busy, done, err, mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
`ifdef MEMCOPY_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    bit [31:0]   mem [0:1023];
    int          waits = 0;
    int          wait_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] rd_log [$];
    logic        stall_pend = 1'b0;
    logic [65:0] stall_snap = '0;

    always #5 clk = ~clk;

    memcopy_sequencer dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MEMCOPY_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    assign mem_ready = (wait_cnt >= waits);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (!rst_n) wait_cnt <= 0;
        else if (mem_rd_en || mem_wr_en) wait_cnt <= mem_ready ? 0 : wait_cnt + 1;
        if (rst_n && mem_wr_en && mem_ready) mem[mem_addr[11:2]] = mem_wdata;
    end

    always @(negedge clk) begin
        checks++;
        if (mem_rd_en && mem_wr_en) begin
            errors++;
            $display("FAIL rd_wr_exclusive: both enables high");
        end
        if (stall_pend) begin
            checks++;
            if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata} !== stall_snap) begin
                errors++;
                $display("FAIL stall_stable: got %h expected %h",
                         {mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, stall_snap);
            end
        end
        stall_pend = (mem_rd_en || mem_wr_en) && !mem_ready;
        stall_snap = {mem_rd_en, mem_wr_en, mem_addr, mem_wdata};
        if (mem_rd_en && mem_ready) begin
            rd_cnt++;
            rd_log.push_back(mem_addr);
        end
        if (mem_wr_en && mem_ready) wr_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic fill_src(input logic [31:0] src, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = src + 32'(4 * i);
            mem[a[11:2]] = 32'hA0 + 32'(i);
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          waits;
        logic        exp_err;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          cyc, busy_cyc;
        logic [31:0] a;

        vecs[0] = '{32'h100, 32'h200, 16'd4, 0, 1'b0, 10, 4};
        vecs[1] = '{32'h100, 32'h200, 16'd4, 2, 1'b0, 26, 4};
        vecs[2] = '{32'h100, 32'h200, 16'd0, 0, 1'b0, 2, 0};
        vecs[3] = '{32'h102, 32'h200, 16'd3, 0, 1'b1, 2, 0};
        vecs[4] = '{32'h100, 32'h203, 16'd1, 0, 1'b1, 2, 0};
        vecs[5] = '{32'hFFFF_FFFC, 32'h300, 16'd2, 0, 1'b0, 6, 2};

        clear_mem();
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            clear_mem();
            fill_src(vecs[v].src, int'(vecs[v].len));
            waits = vecs[v].waits;
            rd_cnt = 0; wr_cnt = 0; rd_log.delete();
            pulse_start(vecs[v].src, vecs[v].dst, vecs[v].len);
            cyc = 0; busy_cyc = 0;
            while (cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (busy) busy_cyc++;
                if (done) break;
            end
            check($sformatf("v%0d_latency", v), 32'(cyc), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_busy_cycles", v), 32'(busy_cyc), 32'(vecs[v].exp_lat - 1));
            check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_reads", v), 32'(rd_cnt), 32'(vecs[v].exp_acc));
            check($sformatf("v%0d_writes", v), 32'(wr_cnt), 32'(vecs[v].exp_acc));
            for (int i = 0; i < vecs[v].exp_acc; i++) begin
                a = vecs[v].dst + 32'(4 * i);
                check($sformatf("v%0d_dst%0d", v, i), mem[a[11:2]], 32'hA0 + 32'(i));
            end
            @(negedge clk);
            check($sformatf("v%0d_err_cleared", v), 32'(err), 32'd0);
        end
        check("wrap_read_addr", (rd_log.size() == 2) ? rd_log[1] : 32'hDEAD_BEEF, 32'h0);

        // Second start while busy must be ignored.
        waits = 0; clear_mem(); fill_src(32'h100, 2); done_cnt = 0;
        pulse_start(32'h100, 32'h200, 16'd2);
        @(negedge clk);
        start = 1'b1; dst_addr = 32'h300;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("ignored_start_done_cnt", 32'(done_cnt), 32'd1);
        check("ignored_start_dst0", mem[32'h200 >> 2], 32'hA0);
        check("ignored_start_dst1", mem[32'h204 >> 2], 32'hA1);
        check("ignored_start_alt", mem[32'h300 >> 2], 32'h0);

        // Reset mid-copy after the second write.
        clear_mem(); fill_src(32'h100, 4); wr_cnt = 0; rd_cnt = 0;
        pulse_start(32'h100, 32'h200, 16'd4);
        cyc = 0;
        while (wr_cnt < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reached", 32'(wr_cnt >= 2), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {27'd0, busy, done, err, mem_rd_en, mem_wr_en}, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        cyc = rd_cnt + wr_cnt;
        repeat (3) @(negedge clk);
        check("rst_mid_no_traffic", 32'(rd_cnt + wr_cnt), 32'(cyc));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_idle", 32'(busy), 32'd0);
        check("rst_mid_dst0", mem[32'h200 >> 2], 32'hA0);
        check("rst_mid_dst1", mem[32'h204 >> 2], 32'hA1);
        check("rst_mid_dst2", mem[32'h208 >> 2], 32'h0);
        check("rst_mid_dst3", mem[32'h20C >> 2], 32'h0);

`ifdef MEMCOPY_ABORT_EN
        waits = 2; clear_mem(); fill_src(32'h100, 8); rd_cnt = 0; wr_cnt = 0;
        pulse_start(32'h100, 32'h200, 16'd8);
        cyc = 0;
        while (!(mem_rd_en && rd_cnt == 2 && !mem_ready) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_done", 32'(done), 32'd1);
        check("abort_flag", 32'(aborted), 32'd1);
        check("abort_reads", 32'(rd_cnt), 32'd3);
        check("abort_writes", 32'(wr_cnt), 32'd2);
        check("abort_dst1", mem[32'h204 >> 2], 32'hA1);
        check("abort_dst2", mem[32'h208 >> 2], 32'h0);
        @(negedge clk);
        check("abort_flag_clear", 32'(aborted), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
